// File: rtl/caesar_decipher_stream.sv
// Caesar deciphering stream: inverts a left/right letter shift, queues results in a 2-entry FIFO.
// Latency: 1 cycle from input handshake to out_valid when the FIFO is empty.
// Backpressure: in_ready drops when the FIFO is full or a key change is draining; no path from out_ready.
module caesar_decipher_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic        key_shift_dir,
    input  logic [4:0]  key_shift_num,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  ctxt_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  ptxt_char,
    output logic        err_invalid_key_shift_num,
    output logic        err_invalid_ctxt_char,
    output logic [15:0] char_count,
    output logic [7:0]  err_count
);

    localparam logic [1:0] NOKEY = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state;

    // Active key decodes characters; shadow key holds a change waiting for the FIFO to drain.
    logic       act_dir;
    logic [4:0] act_num;
    logic       sh_dir;
    logic [4:0] sh_num;

    // FIFO entry layout: {ptxt_char[7:0], err_key, err_char}
    logic [9:0] fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;
    logic [9:0] head;

    logic push;
    logic pop;

    logic       is_upper;
    logic       is_lower;
    logic [7:0] lo_bound;
    logic [7:0] hi_bound;
    logic [7:0] shifted;
    logic [7:0] dec_char;
    logic       dec_err_key;
    logic       dec_err_char;

    assign in_ready  = (state == RUN) && (fifo_count < 2'd2);
    assign out_valid = (fifo_count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = fifo_mem[rd_ptr];

    // Empty FIFO presents all-zero outputs rather than a stale slot.
    assign ptxt_char                 = out_valid ? head[9:2] : 8'h00;
    assign err_invalid_key_shift_num = out_valid & head[1];
    assign err_invalid_ctxt_char     = out_valid & head[0];

    // Undo the encryptor's shift within the letter's own case range.
    always_comb begin
        is_upper     = (ctxt_char >= 8'h41) && (ctxt_char <= 8'h5A);
        is_lower     = (ctxt_char >= 8'h61) && (ctxt_char <= 8'h7A);
        lo_bound     = is_upper ? 8'h41 : 8'h61;
        hi_bound     = is_upper ? 8'h5A : 8'h7A;
        dec_err_key  = (act_num > 5'd26);
        dec_err_char = !(is_upper || is_lower);
        shifted      = ctxt_char;
        if (!act_dir) begin
            shifted = ctxt_char - {3'b000, act_num};
            if (shifted < lo_bound) begin
                shifted = shifted + 8'd26;
            end
        end else begin
            shifted = ctxt_char + {3'b000, act_num};
            if (shifted > hi_bound) begin
                shifted = shifted - 8'd26;
            end
        end
        dec_char = (dec_err_key || dec_err_char) ? 8'h00 : shifted;
    end

    // Key management FSM: a key change waits in the shadow register until queued entries drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NOKEY;
            act_dir <= 1'b0;
            act_num <= 5'd0;
            sh_dir  <= 1'b0;
            sh_num  <= 5'd0;
        end else begin
            case (state)
                NOKEY: begin
                    if (key_load) begin
                        act_dir <= key_shift_dir;
                        act_num <= key_shift_num;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (key_load) begin
                        if ((fifo_count == 2'd0) && !push) begin
                            act_dir <= key_shift_dir;
                            act_num <= key_shift_num;
                        end else begin
                            sh_dir <= key_shift_dir;
                            sh_num <= key_shift_num;
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (key_load) begin
                        sh_dir <= key_shift_dir;
                        sh_num <= key_shift_num;
                    end
                    if (fifo_count == 2'd0) begin
                        // A key arriving in the same cycle as the switch-over is the newest one.
                        act_dir <= key_load ? key_shift_dir : sh_dir;
                        act_num <= key_load ? key_shift_num : sh_num;
                        state   <= RUN;
                    end
                end
                default: begin
                    state <= NOKEY;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop in one edge leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage; contents are meaningless while the count says empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {dec_char, dec_err_key, dec_err_char};
        end
    end

    // Output handshake statistics: total wraps, error count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_count <= 16'd0;
            err_count  <= 8'd0;
        end else if (pop) begin
            char_count <= char_count + 16'd1;
            if ((head[1] || head[0]) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_caesar_decipher_stream.sv
// Bench for caesar_decipher_stream: directed vectors, queue-based reference model, per-cycle compare.
// Inputs change 1 time unit after the rising edge; the model advances on the rising edge.
// Outputs are compared against the model on every falling edge, plus literal spot checks.
module tb_caesar_decipher_stream;

    logic        clk;
    logic        rst;
    logic        key_load;
    logic        key_shift_dir;
    logic [4:0]  key_shift_num;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  ctxt_char;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  ptxt_char;
    logic        err_invalid_key_shift_num;
    logic        err_invalid_ctxt_char;
    logic [15:0] char_count;
    logic [7:0]  err_count;

    caesar_decipher_stream dut (
        .clk                       (clk),
        .rst                       (rst),
        .key_load                  (key_load),
        .key_shift_dir             (key_shift_dir),
        .key_shift_num             (key_shift_num),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .ctxt_char                 (ctxt_char),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .ptxt_char                 (ptxt_char),
        .err_invalid_key_shift_num (err_invalid_key_shift_num),
        .err_invalid_ctxt_char     (err_invalid_ctxt_char),
        .char_count                (char_count),
        .err_count                 (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] p;
        logic       ek;
        logic       ec;
    } ent_t;

    ent_t       q[$];
    int         m_mode;      // 0 = waiting for key, 1 = running, 2 = key change pending
    logic       mk_dir;
    logic [4:0] mk_num;
    logic       ms_dir;
    logic [4:0] ms_num;
    int         m_chars;
    int         m_errs;
    int         size0;
    bit         in_hs;
    bit         out_hs;
    ent_t       popped;

    function automatic ent_t model_decode(input logic [7:0] c, input logic d, input logic [4:0] n);
        ent_t e;
        int   base;
        int   idx;
        e.p  = 8'h00;
        e.ek = (int'(n) > 26);
        e.ec = 1'b0;
        if (int'(c) >= 65 && int'(c) <= 90) base = 65;
        else if (int'(c) >= 97 && int'(c) <= 122) base = 97;
        else begin
            e.ec = 1'b1;
            return e;
        end
        if (e.ek) return e;
        idx = int'(c) - base;
        if (d) idx = (idx + int'(n)) % 26;
        else   idx = (idx - int'(n) + 26) % 26;
        e.p = 8'(base + idx);
        return e;
    endfunction

    function automatic bit m_in_ready();
        return (m_mode == 1) && (q.size() < 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_mode  = 0;
            mk_dir  = 1'b0;
            mk_num  = 5'd0;
            ms_dir  = 1'b0;
            ms_num  = 5'd0;
            m_chars = 0;
            m_errs  = 0;
        end else begin
            size0  = q.size();
            in_hs  = in_valid && m_in_ready();
            out_hs = (size0 != 0) && out_ready;
            if (out_hs) begin
                popped  = q.pop_front();
                m_chars = (m_chars + 1) % 65536;
                if ((popped.ek || popped.ec) && m_errs < 255) m_errs++;
            end
            if (in_hs) q.push_back(model_decode(ctxt_char, mk_dir, mk_num));
            case (m_mode)
                0: if (key_load) begin
                    mk_dir = key_shift_dir; mk_num = key_shift_num; m_mode = 1;
                end
                1: if (key_load) begin
                    if (size0 == 0 && !in_hs) begin
                        mk_dir = key_shift_dir; mk_num = key_shift_num;
                    end else begin
                        ms_dir = key_shift_dir; ms_num = key_shift_num; m_mode = 2;
                    end
                end
                default: begin
                    if (key_load) begin
                        ms_dir = key_shift_dir; ms_num = key_shift_num;
                    end
                    if (size0 == 0) begin
                        mk_dir = ms_dir; mk_num = ms_num; m_mode = 1;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        ent_t h;
        h.p = 8'h00; h.ek = 1'b0; h.ec = 1'b0;
        if (q.size() != 0) h = q[0];
        chk("cyc_in_ready",  32'(in_ready),  32'(m_in_ready()));
        chk("cyc_out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("cyc_ptxt",      32'(ptxt_char), 32'(h.p));
        chk("cyc_err_key",   32'(err_invalid_key_shift_num), 32'(h.ek));
        chk("cyc_err_char",  32'(err_invalid_ctxt_char), 32'(h.ec));
        chk("cyc_char_count", 32'(char_count), 32'(m_chars));
        chk("cyc_err_count",  32'(err_count),  32'(m_errs));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic d, input logic [4:0] n);
        key_load      = 1'b1;
        key_shift_dir = d;
        key_shift_num = n;
        tick();
        key_load      = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        in_valid  = 1'b1;
        ctxt_char = c;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        total = 0;
        bad   = 0;
        rst = 1'b1; key_load = 1'b0; key_shift_dir = 1'b0; key_shift_num = 5'd0;
        in_valid = 1'b0; ctxt_char = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",   32'(in_ready), 0);
        chk("rst_out_valid",  32'(out_valid), 0);
        chk("rst_ptxt",       32'(ptxt_char), 0);
        chk("rst_char_count", 32'(char_count), 0);
        chk("rst_err_count",  32'(err_count), 0);
        rst = 1'b0;

        // No key loaded yet: nothing accepted.
        send(8'h41);
        chk("nokey_in_ready", 32'(in_ready), 0);
        chk("nokey_out_valid", 32'(out_valid), 0);
        in_valid = 1'b0;

        // Right-shift key recovery.
        load_key(1'b0, 5'd3);
        out_ready = 1'b1;
        send(8'h44);
        chk("r3_D_ptxt", 32'(ptxt_char), 32'h41);
        chk("r3_D_errs", 32'({err_invalid_key_shift_num, err_invalid_ctxt_char}), 0);
        send(8'h61);
        chk("r3_a_ptxt", 32'(ptxt_char), 32'h78);
        chk("r3_a_errs", 32'({err_invalid_key_shift_num, err_invalid_ctxt_char}), 0);
        in_valid = 1'b0;
        tick();

        // Left-shift wrap and non-letter, from fresh counters.
        do_reset();
        load_key(1'b1, 5'd3);
        send(8'h5A);
        chk("l3_Z_ptxt", 32'(ptxt_char), 32'h43);
        chk("l3_Z_errs", 32'({err_invalid_key_shift_num, err_invalid_ctxt_char}), 0);
        send(8'h20);
        chk("l3_sp_ptxt", 32'(ptxt_char), 32'h00);
        chk("l3_sp_errc", 32'(err_invalid_ctxt_char), 1);
        in_valid = 1'b0;
        tick();
        chk("l3_err_count",  32'(err_count), 1);
        chk("l3_char_count", 32'(char_count), 2);

        // Illegal key accepted without a state change.
        load_key(1'b0, 5'd27);
        chk("k27_in_ready", 32'(in_ready), 1);
        send(8'h41);
        chk("k27_ptxt", 32'(ptxt_char), 32'h00);
        chk("k27_errk", 32'(err_invalid_key_shift_num), 1);
        in_valid = 1'b0;
        tick();

        // Backpressure: two acceptances, then stall with the head held.
        load_key(1'b0, 5'd1);
        out_ready = 1'b0;
        send(8'h42);
        send(8'h43);
        chk("bp_in_ready_full", 32'(in_ready), 0);
        send(8'h44);
        chk("bp_head_held", 32'(ptxt_char), 32'h41);
        chk("bp_out_valid", 32'(out_valid), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_second", 32'(ptxt_char), 32'h42);
        chk("bp_in_ready_back", 32'(in_ready), 1);
        tick();

        // Key change with two entries queued.
        out_ready = 1'b0;
        send(8'h42);
        send(8'h43);
        in_valid = 1'b0;
        load_key(1'b0, 5'd2);
        chk("kc_drain_in_ready0", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        chk("kc_old_key_head", 32'(ptxt_char), 32'h42);
        chk("kc_drain_in_ready1", 32'(in_ready), 0);
        waited = 0;
        while (!in_ready && waited < 10) begin
            tick();
            waited++;
        end
        chk("kc_resume", 32'(in_ready), 1);
        send(8'h43);
        chk("kc_new_key", 32'(ptxt_char), 32'h41);
        in_valid = 1'b0;
        tick();

        // Reset with two entries queued.
        out_ready = 1'b0;
        send(8'h43);
        send(8'h44);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_in_ready",  32'(in_ready), 0);
        chk("mr_char_count", 32'(char_count), 0);
        chk("mr_err_count",  32'(err_count), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(8'h45);
            chk("mr_no_accept", 32'(in_ready), 0);
            chk("mr_empty", 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        load_key(1'b0, 5'd2);
        send(8'h45);
        chk("mr_after_key", 32'(ptxt_char), 32'h43);
        in_valid = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/caesar_decipher_stream.md
CAESAR_DECIPHER_STREAM -- requirements
Module: caesar_decipher_stream

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: key_load  in  1  request to load a new key this cycle.
REQ-004 SHALL have port: key_shift_dir  in  1  encryption direction; 0 = right shift used by the encryptor, 1 = left shift used.
REQ-005 SHALL have port: key_shift_num  in  5  encryption shift amount, legal range 0..26.
REQ-006 SHALL have port: in_valid  in  1  ciphertext character valid.
REQ-007 SHALL have port: in_ready  out  1  block accepts a character.
REQ-008 SHALL have port: ctxt_char  in  8  ASCII ciphertext character.
REQ-009 SHALL have port: out_valid  out  1  plaintext entry available.
REQ-010 SHALL have port: out_ready  in  1  consumer accepts the entry.
REQ-011 SHALL have port: ptxt_char  out  8  recovered plaintext character.
REQ-012 SHALL have port: err_invalid_key_shift_num  out  1  the head entry was produced under a key_shift_num greater than 26.
REQ-013 SHALL have port: err_invalid_ctxt_char  out  1  the head entry's ciphertext was not A-Z or a-z.
REQ-014 SHALL have port: char_count  out  16  number of completed output handshakes.
REQ-015 SHALL have port: err_count  out  8  number of completed output handshakes with any error flag set.

Function
REQ-016 SHALL implement an FSM with states NOKEY, RUN and DRAIN.
- NOKEY: reset state; in_ready=0.
- RUN: processing characters.
- DRAIN: a key change is pending.
REQ-017 SHALL, in NOKEY, latch the key on key_load and enter RUN on the next cycle.
REQ-018 SHALL, in RUN, treat key_load as follows:
- If the FIFO is empty and no input handshake occurs that cycle, load the key directly.
- Otherwise, store the key in a shadow register and enter DRAIN.
REQ-019 SHALL, in DRAIN, behave as follows:
- Hold in_ready=0.
- A further key_load overwrites the shadow key.
- Once the FIFO is empty, copy the shadow key to the active key and return to RUN.
REQ-020 SHALL accept keys greater than 26 without an FSM change; characters processed under such a key get err_invalid_key_shift_num=1 and ptxt_char=8'h00.
REQ-021 SHALL drive in_ready = (state==RUN) && (fifo_count<2), with no combinational path from out_ready.
REQ-022 SHALL transfer an input character on in_valid && in_ready at a rising edge.
REQ-023 SHALL compute the inverse shift with 8-bit arithmetic:
- dir=0: subtract key_shift_num; add 26 if the result falls below the letter's 'A' or 'a'.
- dir=1: add key_shift_num; subtract 26 if the result exceeds the letter's 'Z' or 'z'.
- Letter case is preserved.
REQ-024 SHALL output ptxt_char=8'h00 with err_invalid_ctxt_char=1 for any non-letter input, including 8'h00.
REQ-025 SHALL push the entry {ptxt_char, both error flags} into a 2-entry FIFO in the same edge as the input handshake, giving 1-cycle latency when the FIFO is empty.
REQ-026 SHALL present the FIFO head combinationally on ptxt_char and the error flags; out_valid = fifo_count!=0.
REQ-027 SHALL pop on out_valid && out_ready.
- Simultaneous push and pop keeps the count unchanged and preserves order.
- Outputs are held stable while out_valid=1 and out_ready=0.
REQ-028 SHALL drive ptxt_char and the error flags to 0 whenever the FIFO is empty.
REQ-029 SHALL increment char_count on every output handshake, wrapping from 16'hFFFF to 0.
REQ-030 SHALL increment err_count on output handshakes whose entry has either error flag set, saturating at 8'hFF.

Reset
REQ-031 SHALL, while rst=1 (asynchronously), force the following:
- state=NOKEY; FIFO emptied; active and shadow key cleared.
- in_ready=0, out_valid=0, ptxt_char=8'h00, both error flags 0, char_count=0, err_count=0.
REQ-032 SHALL discard any FIFO contents and pending key on mid-operation reset, and require a new key_load after reset release.

Verification
REQ-033 SHALL cover right-shift key recovery: key dir=0, num=3; send 8'h44 ('D') and then 8'h61 ('a'), with out_ready=1 -> 8'h41 ('A') and 8'h78 ('x'), each 1 cycle after acceptance, no error flags.
REQ-034 SHALL cover left-shift key wrap: key dir=1, num=3; send 8'h5A ('Z') and then 8'h20 (' ') -> 8'h43 ('C') with no errors, then 8'h00 with err_invalid_ctxt_char=1; err_count=1, char_count=2.
REQ-035 SHALL cover an illegal key: key num=27; send 8'h41 -> 8'h00 with err_invalid_key_shift_num=1.
REQ-036 SHALL cover backpressure: out_ready=0 and in_valid=1 for 3 cycles -> in_ready drops after 2 acceptances and the head is held stable; raise out_ready -> entries emerge in order and in_ready reasserts.
REQ-037 SHALL cover a key change mid-stream: FIFO holds 2 entries under num=1; key_load num=2 -> DRAIN with in_ready=0 until both entries pop; the next character decodes with shift 2.
REQ-038 SHALL cover reset mid-operation: rst=1 with 2 entries queued -> out_valid=0, counters=0 and in_ready=0 immediately; after release, no input is accepted until key_load.
